// File: rtl/commit_tracker_if.sv
// Commit-report bus for commit_tracker: per-channel commit inputs, trap code source and run status.
// The master drives commits; the slave (tracker) drives the delayed report, counters and trap status.
interface commit_tracker_if #(
   parameter int CHANNELS = 2
);
   logic                   gate_i;
   logic [CHANNELS-1:0]    commit_valid_i;
   logic [32*CHANNELS-1:0] commit_pc_i;
   logic [32*CHANNELS-1:0] commit_instr_i;
   logic [32*CHANNELS-1:0] commit_wdata_i;
   logic [CHANNELS-1:0]    commit_wreg_i;
   logic [5*CHANNELS-1:0]  commit_waddr_i;
   logic [31:0]            a0_i;

   logic [CHANNELS-1:0]    valid_o;
   logic [CHANNELS-1:0]    wreg_o;
   logic [32*CHANNELS-1:0] pc_o;
   logic [32*CHANNELS-1:0] instr_o;
   logic [32*CHANNELS-1:0] wdata_o;
   logic [5*CHANNELS-1:0]  waddr_o;
   logic [63:0]            cycle_cnt_o;
   logic [63:0]            instr_cnt_o;
   logic                   trap_valid_o;
   logic [7:0]             trap_code_o;
   logic [31:0]            trap_pc_o;
   logic                   timeout_o;
   logic [1:0]             state_o;

   modport master (
      output gate_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_wdata_i,
             commit_wreg_i, commit_waddr_i, a0_i,
      input  valid_o, wreg_o, pc_o, instr_o, wdata_o, waddr_o, cycle_cnt_o, instr_cnt_o,
             trap_valid_o, trap_code_o, trap_pc_o, timeout_o, state_o
   );

   modport slave (
      input  gate_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_wdata_i,
             commit_wreg_i, commit_waddr_i, a0_i,
      output valid_o, wreg_o, pc_o, instr_o, wdata_o, waddr_o, cycle_cnt_o, instr_cnt_o,
             trap_valid_o, trap_code_o, trap_pc_o, timeout_o, state_o
   );
endinterface

// File: rtl/commit_tracker.sv
// Commit tracker: delays per-channel commits by DELAY cycles, counts cycles/commits, stops on trap or idle watchdog.
// Report latency is exactly DELAY cycles; no backpressure, every gated commit is accepted while IDLE/RUN.
module commit_tracker #(
   parameter int          CHANNELS   = 2,
   parameter int          DELAY      = 1,
   parameter logic [31:0] TIMEOUT    = 32'd100000,
   parameter logic [31:0] TRAP_INSTR = 32'h80000000
) (
   input logic             clock,
   input logic             reset_n,
   commit_tracker_if.slave bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_TRAP    = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [63:0] cycle_cnt;
   logic [63:0] instr_cnt;
   logic [31:0] wd_cnt;
   logic [31:0] last_pc;
   logic [31:0] last_pc_nxt;
   logic        trap_valid;
   logic        timeout;
   logic [7:0]  trap_code;
   logic [31:0] trap_pc;

   logic [CHANNELS-1:0]    v_q     [DELAY];
   logic [CHANNELS-1:0]    wreg_q  [DELAY];
   logic [32*CHANNELS-1:0] pc_q    [DELAY];
   logic [32*CHANNELS-1:0] instr_q [DELAY];
   logic [32*CHANNELS-1:0] wdata_q [DELAY];
   logic [5*CHANNELS-1:0]  waddr_q [DELAY];

   logic                live;
   logic                halt_next;
   logic [CHANNELS-1:0] gated;
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] report;
   logic [63:0]         pop;
   logic                hit;
   logic [31:0]         hit_pc;
   logic                expire;
   logic                unused_a0;

   assign live      = ~state[1];
   assign gated     = bus.commit_valid_i & {CHANNELS{bus.gate_i}};
   assign accept    = gated & {CHANNELS{live}};
   assign expire    = (state == S_RUN) && (gated == '0) && (wd_cnt == TIMEOUT - 32'd1);
   assign halt_next = state_nxt[1];
   assign unused_a0 = ^bus.a0_i[31:8];

   // Walk channels in index order; the first trap instruction masks every higher channel.
   always_comb begin
      report      = '0;
      pop         = '0;
      hit         = 1'b0;
      hit_pc      = '0;
      last_pc_nxt = last_pc;
      for (int k = 0; k < CHANNELS; k++) begin
         if (live && v_q[DELAY-1][k] && !hit) begin
            report[k]   = 1'b1;
            pop         = pop + 64'd1;
            last_pc_nxt = pc_q[DELAY-1][32*k +: 32];
            if (instr_q[DELAY-1][32*k +: 32] == TRAP_INSTR) begin
               hit    = 1'b1;
               hit_pc = pc_q[DELAY-1][32*k +: 32];
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (gated != '0) state_nxt = S_RUN;
         S_RUN: begin
            if (hit)         state_nxt = S_TRAP;
            else if (expire) state_nxt = S_TIMEOUT;
         end
         default: state_nxt = state;
      endcase
   end

   // Entering or sitting in a halted state flushes everything still in flight.
   always_ff @(posedge clock) begin
      if (!reset_n || halt_next) begin
         for (int i = 0; i < DELAY; i++) begin
            v_q[i]     <= '0;
            wreg_q[i]  <= '0;
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
            wdata_q[i] <= '0;
            waddr_q[i] <= '0;
         end
      end else begin
         v_q[0]     <= accept;
         wreg_q[0]  <= bus.commit_wreg_i & accept;
         pc_q[0]    <= bus.commit_pc_i;
         instr_q[0] <= bus.commit_instr_i;
         wdata_q[0] <= bus.commit_wdata_i;
         waddr_q[0] <= bus.commit_waddr_i;
         for (int i = 1; i < DELAY; i++) begin
            v_q[i]     <= v_q[i-1];
            wreg_q[i]  <= wreg_q[i-1];
            pc_q[i]    <= pc_q[i-1];
            instr_q[i] <= instr_q[i-1];
            wdata_q[i] <= wdata_q[i-1];
            waddr_q[i] <= waddr_q[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cycle_cnt  <= '0;
         instr_cnt  <= '0;
         wd_cnt     <= '0;
         last_pc    <= '0;
         trap_valid <= 1'b0;
         timeout    <= 1'b0;
         trap_code  <= '0;
         trap_pc    <= '0;
      end else begin
         state   <= state_nxt;
         last_pc <= last_pc_nxt;
         if (live) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (gated != '0)         wd_cnt <= '0;
            else if (state == S_RUN) wd_cnt <= wd_cnt + 32'd1;
         end
         if (state == S_RUN) instr_cnt <= instr_cnt + pop;
         // A trap reported in the expiry cycle takes priority over the watchdog.
         if (state == S_RUN && hit) begin
            trap_valid <= 1'b1;
            trap_pc    <= hit_pc;
            trap_code  <= bus.a0_i[7:0];
         end else if (expire) begin
            timeout <= 1'b1;
            trap_pc <= last_pc_nxt;
         end
      end
   end

   assign bus.valid_o      = report;
   assign bus.wreg_o       = wreg_q[DELAY-1] & report;
   assign bus.pc_o         = pc_q[DELAY-1];
   assign bus.instr_o      = instr_q[DELAY-1];
   assign bus.wdata_o      = wdata_q[DELAY-1];
   assign bus.waddr_o      = waddr_q[DELAY-1];
   assign bus.cycle_cnt_o  = cycle_cnt;
   assign bus.instr_cnt_o  = instr_cnt;
   assign bus.trap_valid_o = trap_valid;
   assign bus.trap_code_o  = trap_code;
   assign bus.trap_pc_o    = trap_pc;
   assign bus.timeout_o    = timeout;
   assign bus.state_o      = state;
endmodule

// File: tb/tb_commit_tracker.sv
// Scoreboard bench for commit_tracker (CHANNELS=2, DELAY=2, TIMEOUT=16): directed commits, trap, watchdog, reset.
module tb_commit_tracker;
   localparam logic [31:0] TRAP = 32'h80000000;
   localparam int          DLY  = 2;

   typedef struct {
      logic [1:0]  vld;
      logic [1:0]  wreg;
      logic [63:0] pc;
      logic [63:0] instr;
      logic [63:0] wdata;
      logic [9:0]  waddr;
      int          at;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   int          cyc = 0;
   int          nchk = 0;
   int          nerr = 0;
   int          m_rst;
   int          n_cmt;
   logic [63:0] exp_icnt;
   logic [63:0] exp_cyc;
   exp_t        sbq[$];
   exp_t        me;
   logic [63:0] mpc;
   logic [9:0]  mad;

   commit_tracker_if #(.CHANNELS(2)) bus ();

   commit_tracker #(
      .CHANNELS(2), .DELAY(DLY), .TIMEOUT(32'd16), .TRAP_INSTR(TRAP)
   ) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      bus.commit_valid_i = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   // Present one commit cycle; expv is the subset the tracker must report DLY cycles later.
   task automatic drive(input logic g, input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] wr, input logic [1:0] expv);
      exp_t e;
      bus.gate_i         = g;
      bus.commit_valid_i = v;
      bus.commit_pc_i    = {pc1, pc0};
      bus.commit_instr_i = {i1, i0};
      bus.commit_wdata_i = {pc1 ^ 32'h5a5a5a5a, pc0 ^ 32'h5a5a5a5a};
      bus.commit_waddr_i = {pc1[6:2], pc0[6:2]};
      bus.commit_wreg_i  = wr;
      if (expv != 2'b00) begin
         e.vld   = expv;
         e.wreg  = wr & expv;
         e.pc    = {pc1, pc0};
         e.instr = {i1, i0};
         e.wdata = {pc1 ^ 32'h5a5a5a5a, pc0 ^ 32'h5a5a5a5a};
         e.waddr = {pc1[6:2], pc0[6:2]};
         e.at    = cyc + DLY;
         sbq.push_back(e);
         exp_icnt = exp_icnt + 64'($countones(expv));
      end
      step();
   endtask

   task automatic do_reset();
      m_rst   = cyc;
      reset_n = 1'b0;
      bus.commit_valid_i = 2'b00;
      step();
      exp_icnt = '0;
      check("rst_state", 64'(bus.state_o), 64'd0);
      check("rst_valid", 64'(bus.valid_o), 64'd0);
      check("rst_wreg", 64'(bus.wreg_o), 64'd0);
      check("rst_cycle_cnt", bus.cycle_cnt_o, 64'd0);
      check("rst_instr_cnt", bus.instr_cnt_o, 64'd0);
      check("rst_trap_valid", 64'(bus.trap_valid_o), 64'd0);
      check("rst_timeout", 64'(bus.timeout_o), 64'd0);
      check("rst_trap_pc", 64'(bus.trap_pc_o), 64'd0);
      check("rst_trap_code", 64'(bus.trap_code_o), 64'd0);
      reset_n = 1'b1;
   endtask

   always @(negedge clock) begin
      if (bus.valid_o != 2'b00) begin
         if (sbq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_report cycle=%0d valid_o=%b required=none", cyc, bus.valid_o);
         end else begin
            me  = sbq.pop_front();
            mpc = {{32{me.vld[1]}}, {32{me.vld[0]}}};
            mad = {{5{me.vld[1]}}, {5{me.vld[0]}}};
            check("report_cycle", 64'(cyc), 64'(me.at));
            check("report_valid", 64'(bus.valid_o), 64'(me.vld));
            check("report_wreg", 64'(bus.wreg_o), 64'(me.wreg));
            check("report_pc", bus.pc_o & mpc, me.pc & mpc);
            check("report_instr", bus.instr_o & mpc, me.instr & mpc);
            check("report_wdata", bus.wdata_o & mpc, me.wdata & mpc);
            check("report_waddr", 64'(bus.waddr_o & mad), 64'(me.waddr & mad));
         end
      end else if (sbq.size() != 0 && sbq[0].at < cyc) begin
         me = sbq.pop_front();
         nchk++;
         nerr++;
         $display("FAIL missing_report cycle=%0d actual=none required_valid=%b at=%0d", cyc, me.vld, me.at);
      end
      check("wreg_without_valid", 64'(bus.wreg_o & ~bus.valid_o), 64'd0);
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      exp_icnt = '0;
      bus.gate_i = 1'b0;
      bus.commit_valid_i = '0;
      bus.commit_pc_i = '0;
      bus.commit_instr_i = '0;
      bus.commit_wdata_i = '0;
      bus.commit_wreg_i = '0;
      bus.commit_waddr_i = '0;
      bus.a0_i = '0;
      step();
      step();
      do_reset();
      idle(2);

      // Gate low: nothing accepted, tracker stays idle.
      for (int i = 0; i < 3; i++) drive(1'b0, 2'b11, 32'h1c000000, 32'h1c000004, TRAP, TRAP, 2'b11, 2'b00);
      idle(3);
      check("gate_off_state", 64'(bus.state_o), 64'd0);
      check("gate_off_icnt", bus.instr_cnt_o, 64'd0);

      drive(1'b1, 2'b11, 32'h1c000000, 32'h1c000004, 32'h00000013, 32'h00a00093, 2'b10, 2'b11);
      drive(1'b1, 2'b01, 32'h1c000008, 32'hdead0000, 32'h00000033, TRAP, 2'b11, 2'b01);
      drive(1'b1, 2'b10, 32'h0badf00c, 32'h1c00000c, 32'h00000013, 32'h00b00113, 2'b01, 2'b10);
      check("first_pair_icnt", bus.instr_cnt_o, 64'd2);
      drive(1'b0, 2'b11, 32'h1c000010, 32'h1c000014, TRAP, TRAP, 2'b11, 2'b00);
      drive(1'b1, 2'b11, 32'h1c000010, 32'h1c000014, 32'h00c00193, 32'h00d00213, 2'b11, 2'b11);
      idle(4);
      check("run_state", 64'(bus.state_o), 64'd1);
      check("mixed_icnt", bus.instr_cnt_o, exp_icnt);

      for (int i = 0; i < 200; i++)
         drive(1'b1, 2'b01, 32'h20000000 + 32'(4 * i), 32'h0, 32'h00100013, 32'h0, 2'b01, 2'b01);
      idle(4);
      check("burst_icnt", bus.instr_cnt_o, exp_icnt);

      // Trap on channel 0 masks the valid channel 1 commit in the same report.
      bus.a0_i = 32'h00000000;
      drive(1'b1, 2'b11, 32'h1c000100, 32'h1c000104, TRAP, 32'h00000013, 2'b11, 2'b01);
      for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, 32'h1c000200, 32'h1c000204, 32'h13, 32'h13, 2'b11, 2'b00);
      idle(3);
      check("trap0_state", 64'(bus.state_o), 64'd2);
      check("trap0_valid", 64'(bus.trap_valid_o), 64'd1);
      check("trap0_code", 64'(bus.trap_code_o), 64'h00);
      check("trap0_pc", 64'(bus.trap_pc_o), 64'h1c000100);
      check("trap0_icnt", bus.instr_cnt_o, exp_icnt);
      check("trap0_timeout", 64'(bus.timeout_o), 64'd0);

      do_reset();
      idle(2);
      // Reset while the delay line holds a commit: it must never surface.
      drive(1'b1, 2'b11, 32'h30000000, 32'h30000004, 32'h13, 32'h13, 2'b11, 2'b11);
      drive(1'b1, 2'b11, 32'h30000008, 32'h3000000c, 32'h13, 32'h13, 2'b11, 2'b00);
      do_reset();
      idle(5);
      check("post_reset_state", 64'(bus.state_o), 64'd0);

      bus.a0_i = 32'h12345aa5;
      drive(1'b1, 2'b11, 32'h1c000300, 32'h1c000304, 32'h00000013, TRAP, 2'b01, 2'b11);
      idle(4);
      check("trap1_state", 64'(bus.state_o), 64'd2);
      check("trap1_code", 64'(bus.trap_code_o), 64'ha5);
      check("trap1_pc", 64'(bus.trap_pc_o), 64'h1c000304);
      check("trap1_icnt", bus.instr_cnt_o, 64'd2);

      do_reset();
      idle(3);
      n_cmt = cyc;
      drive(1'b1, 2'b10, 32'h0, 32'h1c0000f0, 32'h0, 32'h00000013, 2'b10, 2'b10);
      idle(9);
      check("wd_still_run", 64'(bus.state_o), 64'd1);
      idle(10);
      exp_cyc = 64'(n_cmt - m_rst + 16);
      check("timeout_state", 64'(bus.state_o), 64'd3);
      check("timeout_flag", 64'(bus.timeout_o), 64'd1);
      check("timeout_no_trap", 64'(bus.trap_valid_o), 64'd0);
      check("timeout_pc", 64'(bus.trap_pc_o), 64'h1c0000f0);
      check("timeout_icnt", bus.instr_cnt_o, 64'd1);
      check("timeout_cycle_cnt", bus.cycle_cnt_o, exp_cyc);
      drive(1'b1, 2'b11, 32'h1c000400, 32'h1c000404, 32'h13, 32'h13, 2'b11, 2'b00);
      idle(5);
      check("frozen_cycle_cnt", bus.cycle_cnt_o, exp_cyc);
      check("timeout_sticky", 64'(bus.timeout_o), 64'd1);

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/commit_tracker.md
COMMIT_TRACKER -- requirements
Module: commit_tracker

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of commit channels per cycle (legal 1..4).
REQ-002 SHALL have parameter DELAY, default 1, register stages between commit input and report output (legal 1..4).
REQ-003 SHALL have parameter TIMEOUT, default 32'd100000, idle-cycle limit for the watchdog (legal >= 2).
REQ-004 SHALL have parameter TRAP_INSTR, default 32'h80000000, instruction encoding that ends a run.
REQ-005 clock  input  1  sole clock, all state updates on posedge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 gate_i  input  1  commit qualifier; channel valid is commit_valid_i[k] & gate_i.
REQ-008 commit_valid_i  input  CHANNELS  per-channel commit strobe.
REQ-009 commit_pc_i, commit_instr_i, commit_wdata_i  input  32*CHANNELS each  channel k in bits [32k+31:32k].
REQ-010 commit_wreg_i  input  CHANNELS  register-write flag; commit_waddr_i  input  5*CHANNELS  destination index.
REQ-011 a0_i  input  32  architectural r4 value, sampled as trap code.
REQ-012 valid_o, wreg_o  output  CHANNELS; pc_o, instr_o, wdata_o  output  32*CHANNELS; waddr_o  output  5*CHANNELS  delayed commit report.
REQ-013 cycle_cnt_o, instr_cnt_o  output  64 each  run counters.
REQ-014 trap_valid_o  output  1; trap_code_o  output  8; trap_pc_o  output  32; timeout_o  output  1; state_o  output  2.

Function
REQ-015 SHALL implement states IDLE=2'd0, RUN=2'd1, TRAP=2'd2, TIMEOUT=2'd3, driven on state_o.
REQ-016 IDLE -> RUN on first cycle any gated input valid is 1; cycle_cnt_o counts in IDLE and RUN, frozen in TRAP/TIMEOUT.
REQ-017 Each channel's fields SHALL pass through exactly DELAY register stages; gated valid of cycle t appears on valid_o at cycle t+DELAY with matching fields.
REQ-018 Channels SHALL stay independent and in index order; no compaction or reordering.
REQ-019 When valid_o[k]=0, wreg_o[k] SHALL be 0; other fields of that channel are don't-care.
REQ-020 instr_cnt_o SHALL add popcount(valid_o) each cycle in RUN (reported commits, not inputs); 64-bit wrap, no saturation.
REQ-021 Trap: in RUN, lowest k with valid_o[k]=1 and instr_o[k]==TRAP_INSTR SHALL, next cycle, set state TRAP, trap_valid_o=1, trap_pc_o=pc_o[k], trap_code_o=a0_i[7:0] sampled that same cycle.
REQ-022 In the trap cycle, channels j>k SHALL be masked from valid_o and not counted; channel k and j<k are reported and counted.
REQ-023 In TRAP and TIMEOUT, valid_o SHALL be all 0, delay stages flushed, new inputs ignored; only reset exits.
REQ-024 Watchdog: counter clears on any gated input valid, increments otherwise in RUN; on reaching TIMEOUT -> state TIMEOUT, timeout_o=1, trap_pc_o = pc of last reported commit.
REQ-025 Trap and watchdog expiry in same cycle: trap SHALL win; timeout_o stays 0.
REQ-026 trap_valid_o and timeout_o SHALL be sticky until reset.

Reset
REQ-027 reset_n=0 at a posedge SHALL clear state to IDLE, all delay stages, watchdog, both counters, valid_o, wreg_o, trap_valid_o, timeout_o, trap_code_o, trap_pc_o, all to 0.
REQ-028 Reset mid-run SHALL discard in-flight commits; none appear on valid_o after reset release.
REQ-029 Outputs SHALL not change asynchronously to clock.

Verification
REQ-030 CHANNELS=2, DELAY=2: valid_i=2'b11, pc 0x1c000000/0x1c000004 at cycle 5 -> valid_o=2'b11 with same pcs at cycle 7; instr_cnt_o=2 at cycle 8.
REQ-031 gate_i=0 with valid_i=2'b11 -> valid_o stays 0, instr_cnt_o unchanged, state_o stays IDLE.
REQ-032 Trap on channel 0 with channel 1 also valid, a0_i=0x00000000 -> valid_o=2'b01 that cycle, state_o=2, trap_code_o=0x00, instr_cnt_o +1 only.
REQ-033 TIMEOUT=16, one commit then none for 16 cycles -> state_o=3, timeout_o=1, trap_pc_o = that commit's pc, cycle_cnt_o frozen.
REQ-034 reset_n=0 one cycle while DELAY=3 stages full -> all outputs 0, state_o=0, no stale valid_o after release.
REQ-035 CHANNELS=1, DELAY=1, 1000 back-to-back commits -> instr_cnt_o=1000, each pc_o exactly one cycle after its input.
